// File: rtl/rvga_fetch_queue_pkg.sv
// Shared types for the rvga fetch front end: machine word, queue entry, instruction size.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package rvga_types;

   typedef logic [31:0] rvga_word;

   typedef struct packed {
      rvga_word pc;
      rvga_word ir;
   } fetch_entry_s;

   localparam int unsigned RVGA_ILEN_BYTES = 4;

   // Instructions are word aligned; stray low address bits are simply dropped.
   function automatic rvga_word rvga_align(input rvga_word addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/rvga_fetch_queue_fifo.sv
// Generic synchronous FIFO with a same-cycle flush and occupancy count.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over both.
module rvga_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_dat,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_dat,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   // storage; cleared on reset so an idle head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/rvga_fetch_queue.sv
// Fetch front end: in-order pipelined imem requests, responses tagged with PCs and queued for decode.
// Latency: response to ir_v_o 1 cycle through the queue, 0 cycles when built with RVGA_FETCH_BYPASS_EN.
// Backpressure: ir_ready_i stalls pops; requests are withheld once in-flight plus queued work would reach DEPTH.
module rvga_fetch_queue
   import rvga_types::*;
#(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_v_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_resp_v_i,
   input  logic [31:0] imem_data_i,
   input  logic        br_v_i,
   input  logic [31:0] br_tgt_i,
   output logic        ir_v_o,
   input  logic        ir_ready_i,
   output logic [31:0] ir_o,
   output logic [31:0] pc_o
);

   localparam int unsigned IW = $clog2(MAX_OUTSTANDING+1);
   localparam int unsigned CW = $clog2(DEPTH+1);

   rvga_word     fetch_pc;
   rvga_word     resp_pc;
   logic [IW-1:0] inflight;
   logic [IW-1:0] kill;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          req_fire;
   logic          resp_live;
   logic [31:0]   credit_used;
   fetch_entry_s  push_ent;
   fetch_entry_s  head_ent;

   // Live in-flight requests plus queued entries may never exceed the queue size,
   // so every response that survives the kill counter always has a free slot.
   assign credit_used  = 32'(inflight) - 32'(kill) + 32'(fifo_count);
   assign imem_req_v_o = rst_i & ~br_v_i & (32'(inflight) < MAX_OUTSTANDING) & (credit_used < DEPTH);
   assign imem_addr_o  = fetch_pc;
   assign req_fire     = imem_req_v_o & imem_req_ready_i;

   // A response is kept only when no stale responses remain and no redirect is flushing this cycle.
   assign resp_live = imem_resp_v_i & (kill == '0) & ~br_v_i;
   assign push_ent  = '{pc: resp_pc, ir: imem_data_i};

`ifdef RVGA_FETCH_BYPASS_EN
   logic byp_hit;
   assign byp_hit = resp_live & fifo_empty;
   assign ir_v_o  = ~fifo_empty | byp_hit;
   assign ir_o    = byp_hit ? imem_data_i : head_ent.ir;
   assign pc_o    = byp_hit ? resp_pc : head_ent.pc;
   assign push    = resp_live & ~fifo_full & ~(byp_hit & ir_ready_i);
`else
   assign ir_v_o  = ~fifo_empty;
   assign ir_o    = head_ent.ir;
   assign pc_o    = head_ent.pc;
   assign push    = resp_live & ~fifo_full;
`endif

   assign pop = ~fifo_empty & ir_ready_i & ~br_v_i;

   // fetch address, response PC tag and in-flight/stale bookkeeping; redirect takes priority
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         kill     <= '0;
      end else begin
         case ({req_fire, imem_resp_v_i})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: ;
         endcase
         if (br_v_i) begin
            fetch_pc <= rvga_align(br_tgt_i);
            resp_pc  <= rvga_align(br_tgt_i);
            kill     <= inflight - IW'(imem_resp_v_i);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'(RVGA_ILEN_BYTES);
            if (imem_resp_v_i && kill != '0) kill <= kill - 1'b1;
            if (resp_live) resp_pc <= resp_pc + 32'(RVGA_ILEN_BYTES);
         end
      end
   end

   rvga_fifo #(
      .WIDTH ($bits(fetch_entry_s)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .flush    (br_v_i),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .pop_dat  (head_ent),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_rvga_fetch_queue.sv
// Bench for rvga_fetch_queue: vector table, directed corner sequences and a randomized run.
// Latency: n/a.
// Backpressure: imem acceptance, response delay and decode ready are all driven by the bench.
`timescale 1ns/1ps
module tb_rvga_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RVGA_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int OFF = BYP ? 1 : 2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        imem_req_v_o;
   logic        imem_req_ready_i = 1'b0;
   logic [31:0] imem_addr_o;
   logic        imem_resp_v_i = 1'b0;
   logic [31:0] imem_data_i = '0;
   logic        br_v_i = 1'b0;
   logic [31:0] br_tgt_i = '0;
   logic        ir_v_o;
   logic        ir_ready_i = 1'b0;
   logic [31:0] ir_o;
   logic [31:0] pc_o;

   rvga_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .imem_req_v_o     (imem_req_v_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_addr_o      (imem_addr_o),
      .imem_resp_v_i    (imem_resp_v_i),
      .imem_data_i      (imem_data_i),
      .br_v_i           (br_v_i),
      .br_tgt_i         (br_tgt_i),
      .ir_v_o           (ir_v_o),
      .ir_ready_i       (ir_ready_i),
      .ir_o             (ir_o),
      .pc_o             (pc_o)
   );

   always #5 clk_i = ~clk_i;

   // imem request awaiting its response; epoch tells whether a redirect made it stale
   typedef struct { logic [31:0] addr; logic [31:0] data; int epoch; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
   typedef struct {
      bit resp_v; logic [31:0] data; bit req_rdy; bit ir_rdy;
      bit exp_req_v; logic [31:0] exp_addr; bit exp_ir_v; logic [31:0] exp_pc; logic [31:0] exp_ir;
   } vec_t;

   req_t        pending[$];
   ent_t        exp_q[$];
   logic [31:0] hs_q[$];
   logic [31:0] pop_q[$];
   logic [31:0] pop_ir_q[$];
   int          cur_epoch, cycle, lat_lo, lat_hi, max_pend;
   bit          jitter;
   logic [31:0] exp_pc;
   int          n_cmp = 0;
   int          n_fail = 0;
   bit          drv_req_rdy, drv_ir_rdy, drv_br, drv_resp;
   logic [31:0] drv_tgt;
   logic        s_req_v, s_ir_v;
   logic [31:0] s_addr, s_pc, s_ir;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      imem_req_ready_i = 1'b0; imem_resp_v_i = 1'b0; imem_data_i = '0;
      br_v_i = 1'b0; br_tgt_i = '0; ir_ready_i = 1'b0;
      #1;
      chk("rst_req_v", 32'(imem_req_v_o), 0);
      chk("rst_ir_v", 32'(ir_v_o), 0);
      chk("rst_ir", ir_o, 0);
      chk("rst_pc", pc_o, 0);
      pending.delete(); exp_q.delete();
      cur_epoch = 0; exp_pc = RESET_PC;
      drv_br = 1'b0; drv_tgt = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   // One clock: drive inputs, sample outputs, check against the reference model, then advance it.
   task automatic cyc();
      req_t e;
      ent_t vis;
      ent_t n;
      bit   vis_v, byp_hit, live;
      int   live_cnt;
      @(posedge clk_i); #1;
      drv_resp = 1'b0;
      if (pending.size() > 0 && pending[0].due <= cycle)
         drv_resp = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
      imem_resp_v_i    = drv_resp;
      imem_data_i      = drv_resp ? pending[0].data : $urandom;
      imem_req_ready_i = drv_req_rdy;
      ir_ready_i       = drv_ir_rdy;
      br_v_i           = drv_br;
      br_tgt_i         = drv_tgt;
      @(negedge clk_i);
      s_req_v = imem_req_v_o; s_addr = imem_addr_o;
      s_ir_v = ir_v_o; s_pc = pc_o; s_ir = ir_o;

      live    = drv_resp && (pending[0].epoch == cur_epoch);
      vis_v   = exp_q.size() > 0;
      byp_hit = 1'b0;
      vis.pc  = '0; vis.ir = '0;
      if (vis_v) vis = exp_q[0];
      if (BYP && !vis_v && live && !drv_br) begin
         byp_hit = 1'b1; vis_v = 1'b1;
         vis.pc = pending[0].addr; vis.ir = pending[0].data;
      end
      chk("ir_v", 32'(s_ir_v), 32'(vis_v));
      if (vis_v && s_ir_v) begin
         chk("pc", s_pc, vis.pc);
         chk("ir", s_ir, vis.ir);
      end
      live_cnt = 0;
      foreach (pending[i]) if (pending[i].epoch == cur_epoch) live_cnt++;
      chk("req_v", 32'(s_req_v),
          32'(!drv_br && pending.size() < MAXO && (live_cnt + exp_q.size()) < DEPTH));
      if (s_req_v) chk("req_addr", s_addr, exp_pc);

      if (s_req_v && drv_req_rdy) hs_q.push_back(s_addr);
      if (s_ir_v && drv_ir_rdy && !drv_br) begin
         pop_q.push_back(s_pc);
         pop_ir_q.push_back(s_ir);
      end

      if (drv_br) begin
         cur_epoch++;
         exp_q.delete();
         exp_pc = {drv_tgt[31:2], 2'b00};
         if (drv_resp) e = pending.pop_front();
      end else begin
         if (vis_v && drv_ir_rdy && !byp_hit) n = exp_q.pop_front();
         if (drv_resp) begin
            e = pending.pop_front();
            if (e.epoch == cur_epoch && !(byp_hit && drv_ir_rdy)) begin
               n.pc = e.addr; n.ir = e.data;
               exp_q.push_back(n);
            end
         end
         if (s_req_v && drv_req_rdy) begin
            e.addr  = s_addr;
            e.data  = data_of(s_addr);
            e.epoch = cur_epoch;
            e.due   = cycle + $urandom_range(lat_lo, lat_hi);
            pending.push_back(e);
            exp_pc += 32'd4;
         end
      end
      if (pending.size() > max_pend) max_pend = pending.size();
      cycle++;
   endtask

   task automatic clear_obs();
      hs_q.delete(); pop_q.delete(); pop_ir_q.delete();
   endtask

   task automatic run_until(input int n_hs, input int n_pop, input int budget, input string name);
      int k = 0;
      while ((hs_q.size() < n_hs || pop_q.size() < n_pop) && k < budget) begin
         cyc();
         k++;
      end
      n_cmp++;
      if (hs_q.size() < n_hs || pop_q.size() < n_pop) begin
         n_fail++;
         $display("FAIL %s timeout: requests %0d pops %0d, needed %0d/%0d", name,
                  hs_q.size(), pop_q.size(), n_hs, n_pop);
      end
   endtask

   task automatic redirect(input logic [31:0] tgt);
      drv_br = 1'b1; drv_tgt = tgt;
      cyc();
      chk("br_no_req", 32'(s_req_v), 0);
      drv_br = 1'b0;
      clear_obs();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      int   k;
      int   ir_mode;
      cycle = 0; lat_lo = 1; lat_hi = 1; jitter = 1'b0; max_pend = 0;
      drv_req_rdy = 1'b0; drv_ir_rdy = 1'b0; drv_br = 1'b0; drv_tgt = '0; drv_resp = 1'b0;
      cur_epoch = 0; exp_pc = RESET_PC;

      // streaming vectors: imem always ready, 1-cycle responses, decode always ready
      for (int r = 0; r < 8; r++) begin
         tbl[r].resp_v    = (r >= 1);
         tbl[r].data      = data_of(32'(4 * (r - 1)));
         tbl[r].req_rdy   = 1'b1;
         tbl[r].ir_rdy    = 1'b1;
         tbl[r].exp_req_v = 1'b1;
         tbl[r].exp_addr  = 32'(4 * r);
         tbl[r].exp_ir_v  = (r >= OFF);
         tbl[r].exp_pc    = 32'(4 * (r - OFF));
         tbl[r].exp_ir    = data_of(32'(4 * (r - OFF)));
      end

      do_reset();
      for (int r = 0; r < 8; r++) begin
         @(posedge clk_i); #1;
         imem_resp_v_i    = tbl[r].resp_v;
         imem_data_i      = tbl[r].data;
         imem_req_ready_i = tbl[r].req_rdy;
         ir_ready_i       = tbl[r].ir_rdy;
         br_v_i           = 1'b0;
         @(negedge clk_i);
         chk($sformatf("vec%0d_req_v", r), 32'(imem_req_v_o), 32'(tbl[r].exp_req_v));
         chk($sformatf("vec%0d_addr", r), imem_addr_o, tbl[r].exp_addr);
         chk($sformatf("vec%0d_ir_v", r), 32'(ir_v_o), 32'(tbl[r].exp_ir_v));
         if (tbl[r].exp_ir_v) begin
            chk($sformatf("vec%0d_pc", r), pc_o, tbl[r].exp_pc);
            chk($sformatf("vec%0d_ir", r), ir_o, tbl[r].exp_ir);
         end
      end

      // decode stalled: exactly DEPTH requests, then drain in order
      do_reset();
      lat_lo = 1; lat_hi = 1; jitter = 1'b0;
      drv_req_rdy = 1'b1; drv_ir_rdy = 1'b0;
      clear_obs();
      repeat (12) cyc();
      chk("bp_accepted", 32'(hs_q.size()), DEPTH);
      chk("bp_req_stall", 32'(s_req_v), 0);
      drv_ir_rdy = 1'b1;
      clear_obs();
      run_until(0, 4, 20, "bp_drain");
      for (int i = 0; i < 4; i++) chk($sformatf("bp_pc%0d", i), pop_q[i], 32'(4 * i));

      // slow imem: never more than MAX_OUTSTANDING unanswered
      do_reset();
      lat_lo = 5; lat_hi = 5; max_pend = 0;
      drv_req_rdy = 1'b1; drv_ir_rdy = 1'b1;
      repeat (30) cyc();
      chk("max_outstanding", 32'(max_pend), MAXO);

      // redirect with two requests in flight: both stale responses dropped
      do_reset();
      k = 0;
      while (pending.size() < 2 && k < 10) begin cyc(); k++; end
      chk("br2_inflight", 32'(pending.size()), 2);
      redirect(32'h0000_0100);
      run_until(1, 1, 40, "br2_first");
      chk("br2_req_addr", hs_q[0], 32'h0000_0100);
      chk("br2_first_pc", pop_q[0], 32'h0000_0100);
      chk("br2_first_ir", pop_ir_q[0], data_of(32'h0000_0100));

      // redirect coinciding with a response while two are in flight: one more response dropped
      do_reset();
      lat_lo = 2; lat_hi = 2;
      k = 0;
      while (!(pending.size() == 2 && pending[0].due <= cycle) && k < 10) begin cyc(); k++; end
      redirect(32'h0000_0200);
      run_until(1, 1, 40, "brr_first");
      chk("brr_req_addr", hs_q[0], 32'h0000_0200);
      chk("brr_first_pc", pop_q[0], 32'h0000_0200);
      chk("brr_first_ir", pop_ir_q[0], data_of(32'h0000_0200));

      // address wrap and misaligned target
      do_reset();
      lat_lo = 1; lat_hi = 1;
      redirect(32'hFFFF_FFFC);
      run_until(3, 2, 30, "wrap");
      chk("wrap_req0", hs_q[0], 32'hFFFF_FFFC);
      chk("wrap_req1", hs_q[1], 32'h0000_0000);
      chk("wrap_req2", hs_q[2], 32'h0000_0004);
      chk("wrap_pc0", pop_q[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", pop_q[1], 32'h0000_0000);
      redirect(32'h0000_0103);
      run_until(1, 1, 30, "misalign");
      chk("misalign_req", hs_q[0], 32'h0000_0100);
      chk("misalign_pc", pop_q[0], 32'h0000_0100);
      chk("misalign_ir", pop_ir_q[0], data_of(32'h0000_0100));

`ifdef RVGA_FETCH_BYPASS_EN
      // bypass: a response into an empty queue reaches decode in the same cycle
      do_reset();
      lat_lo = 1; lat_hi = 1;
      k = 0;
      cyc();
      while (!drv_resp && k < 10) begin cyc(); k++; end
      chk("byp_same_cycle_v", 32'(s_ir_v), 1);
      chk("byp_same_cycle_pc", s_pc, RESET_PC);
`endif

      // randomized traffic against the reference model, with one reset mid-run
      do_reset();
      lat_lo = 1; lat_hi = 4; jitter = 1'b1;
      ir_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         if (c % 50 == 0) ir_mode = $urandom_range(0, 3);
         drv_req_rdy = ($urandom_range(0, 3) != 0);
         drv_ir_rdy  = (ir_mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         drv_br      = ($urandom_range(0, 24) == 0);
         drv_tgt     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : ($urandom & 32'h0000_3FFF);
         clear_obs();
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rvga_fetch_queue.md
Name: rvga_fetch_queue

Overview:
- Parametrised next-generation instruction fetch front end.
- Issues pipelined, in-order requests to imem, keeps up to MAX_OUTSTANDING requests in flight, and buffers returned instructions with their PCs in a DEPTH-entry queue.
- Presents instructions to decode over a valid/ready handshake.
- A branch redirect flushes the queue and discards stale in-flight responses.

Parameters:
- DEPTH, 4, instruction queue entries (power of two, >=2)
- MAX_OUTSTANDING, 2, maximum imem requests in flight (>=1)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- imem_req_v_o  out  1  request valid
- imem_req_ready_i  in  1  imem accepts request
- imem_addr_o  out  32  request address (rvga_word)
- imem_resp_v_i  in  1  response valid, in order, one per accepted request
- imem_data_i  in  32  response instruction word
- br_v_i  in  1  redirect strobe
- br_tgt_i  in  32  redirect target
- ir_v_o  out  1  instruction valid to decode
- ir_ready_i  in  1  decode accepts
- ir_o  out  32  instruction word
- pc_o  out  32  PC of ir_o

Behaviour:
- Reset (rst_i low, asynchronous):
  - fetch_pc=RESET_PC; inflight=0; kill=0; queue empty.
  - imem_req_v_o=0, ir_v_o=0, ir_o=0, pc_o=0.
  - First request is asserted in the first cycle after reset deasserts.
  - Reset mid-operation drops everything; stale responses arriving after reset are ignored only if kill>0, so imem is reset together with this block.
- Request issue:
  - imem_req_v_o=1 when all of the following hold: !br_v_i, inflight<MAX_OUTSTANDING, (inflight-kill)+count<DEPTH.
  - This credit rule guarantees the queue can never overflow.
  - imem_addr_o=fetch_pc.
  - Handshake = imem_req_v_o & imem_req_ready_i. On handshake: fetch_pc+=4 (32-bit wrap from 32'hFFFF_FFFC to 0), inflight+=1.
- Response:
  - Each imem_resp_v_i decrements inflight.
  - If kill>0: kill-=1 and data is dropped.
  - Otherwise push {resp_pc, imem_data_i}; resp_pc starts at the stream's first address and increments by 4 per accepted response.
- Pop: ir_v_o=!empty; ir_o/pc_o = head entry; pop on ir_v_o&ir_ready_i.
- Simultaneous push and pop when full: cannot occur, by the credit rule.
- Simultaneous push and pop otherwise: count unchanged.
- Latency: response to ir_v_o is 1 cycle (registered queue), unless RVGA_FETCH_BYPASS_EN.
- Redirect (br_v_i=1, highest priority), in the same cycle:
  - Queue flushed (count=0); pop and push ignored; ir_v_o still shows the old head, but decode must treat it as killed.
  - kill <= inflight - imem_resp_v_i, where inflight is the count before this cycle.
  - fetch_pc <= br_tgt_i; resp_pc <= br_tgt_i; no request issued.
  - Back-to-back redirects: kill recomputed each time, last target wins.
- Misaligned br_tgt_i (low bits !=0): low two bits forced to 0.
- Counter widths: $clog2(MAX_OUTSTANDING+1) for inflight and kill; $clog2(DEPTH+1) for count.

Optional Feature:
- Macro: RVGA_FETCH_BYPASS_EN.
- Defined: when the queue is empty, kill==0, !br_v_i and imem_resp_v_i, the response drives ir_v_o/ir_o/pc_o combinationally in the same cycle.
  - If ir_ready_i, it is consumed without a push.
  - Otherwise it is pushed normally.
- Undefined: ir_v_o is driven only from queue state (registered); 1-cycle minimum latency.

Decomposition:
- rvga_types package:
  - rvga_word
  - fetch_entry_s {rvga_word pc; rvga_word ir;}
  - RVGA_ILEN_BYTES=4
- Sub-module rvga_fifo: parametrised synchronous FIFO with WIDTH and DEPTH, plus a flush input, push/pop, full/empty/count outputs.
- rvga_fetch_queue instantiates it with fetch_entry_s.

Test Plan:
- Reset release, imem always ready, 1-cycle responses, decode always ready:
  - requests go to 0x0,0x4,0x8…
  - ir_v_o with pc_o=0x0 two cycles after the first request (bypass off).
- ir_ready_i held low, DEPTH=4:
  - exactly 4 requests are accepted, then imem_req_v_o=0.
  - Releasing ready yields PCs 0x0..0xC in order with no loss.
- MAX_OUTSTANDING=2, imem_req_ready_i=1, responses delayed 5 cycles: never more than 2 unanswered requests.
- With 2 in flight, br_v_i=1, br_tgt_i=0x100:
  - both stale responses are dropped.
  - First ir_o delivered has pc_o=0x100; the next request address is 0x100.
- Redirect in the same cycle as imem_resp_v_i with inflight=2: kill=1; exactly one further response is dropped.
- fetch_pc=0xFFFF_FFFC wraps to 0x0; br_tgt_i=0x103 fetches 0x100.
- With RVGA_FETCH_BYPASS_EN, empty queue, ready decode: ir_v_o is asserted in the same cycle as imem_resp_v_i.
